seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider, the inverse of the arithmetic unit's multiply path. It accepts a DIVIDEND_W-bit dividend and a DIVISOR_W-bit divisor over a valid/ready handshake and produces one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits downstream of the ALU result bus, so a 4-bit ALU product can be divided back by a 2-bit operand.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/div_step.sv | 34 +++
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: FSM state encoding, default operand widths and the step counter
//          width helper used by seq_divider and div_step.
// Ports:   none (package).
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DIVIDEND_W = 4;
  localparam int DIV_DIVISOR_W  = 2;

  // Counter must hold 0..dividend_w so the last step index is representable.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder, tries a
//          subtraction of the divisor and restores if it would go negative.
// Ports:   part_rem  partial remainder from the previous step
//          in_bit    next dividend bit (MSB first)
//          divisor   unsigned divisor
//          next_rem  partial remainder after this step
//          q_bit     quotient bit produced by this step
module div_step
  import seq_div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] part_rem,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] next_rem,
  output logic                 q_bit
);

  // The partial remainder is always below the divisor, so it fits in
  // DIVISOR_W bits; the trial value needs one extra bit after the shift.
  logic [DIVISOR_W:0] trial;

  assign trial = {part_rem, in_bit};
  assign q_bit = (trial >= {1'b0, divisor});

  // Both results fit in DIVISOR_W bits: a successful subtraction leaves a
  // value below the divisor, and with a zero divisor the top bit is shifted
  // out on the next step anyway.
  assign next_rem = DIVISOR_W'(q_bit ? (trial - {1'b0, divisor}) : trial);

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose: accepts dividend/divisor over a valid/ready handshake, iterates
//          DIVIDEND_W restoring steps and returns quotient, remainder and a
//          divide-by-zero flag over a second valid/ready handshake.
// Config:  SEQ_DIV_ZERO_CHECK_EN - when defined, a zero divisor skips the
//          iteration and reports o_dbz=1; otherwise o_dbz is tied 0.
// Ports:   i_clk, i_rst_n (async assert, active-low)
//          i_valid/o_ready, i_dividend, i_divisor   operand handshake
//          o_valid/i_ready, o_quotient, o_remainder, o_dbz   result handshake
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DIVIDEND_W-1:0] o_quotient,
  output logic [DIVISOR_W-1:0]  o_remainder,
  output logic                  o_dbz
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  // Dividend bits leave from the MSB while quotient bits enter at the LSB,
  // so one register serves both; after DIVIDEND_W steps it holds the quotient.
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  rem_next;
  logic                  q_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .part_rem (rem),
    .in_bit   (dq[DIVIDEND_W-1]),
    .divisor  (dvs),
    .next_rem (rem_next),
    .q_bit    (q_bit)
  );

`ifdef SEQ_DIV_ZERO_CHECK_EN
  logic dbz_q;
  assign o_dbz = dbz_q;
`else
  assign o_dbz = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            dq      <= i_dividend;
            dvs     <= i_divisor;
            rem     <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            if (i_divisor == '0) begin
              // Report the same values the full iteration would produce.
              state       <= DONE;
              o_valid     <= 1'b1;
              o_quotient  <= '1;
              o_remainder <= i_dividend[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
            end else begin
              state <= CALC;
              dbz_q <= 1'b0;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          dq  <= {dq[DIVIDEND_W-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state       <= DONE;
            o_valid     <= 1'b1;
            o_quotient  <= {dq[DIVIDEND_W-2:0], q_bit};
            o_remainder <= rem_next;
          end
        end

        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider
module tb_seq_divider;

  localparam int DW = 4;
  localparam int SW = 2;
`ifdef SEQ_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    int            k;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_dividend = '0;
  logic [SW-1:0] i_divisor = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_quotient;
  logic [SW-1:0] o_remainder;
  logic          o_dbz;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   inflight = 0;
  bit   hs_pending = 0;
  bit   mon_en = 0;
  bit   bp_en = 0;

  seq_divider dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_dbz       (o_dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int k);
    exp_t e;
    if (b == 0) begin
      e.q   = DW'((1 << DW) - 1);
      e.r   = SW'(a % (1 << SW));
      e.dbz = ZC;
      e.lat = ZC ? 0 : DW;
    end else begin
      e.q   = DW'(a / b);
      e.r   = SW'(a % b);
      e.dbz = 1'b0;
      e.lat = DW;
    end
    e.k = k;
    return e;
  endfunction

  // Handshake completes on the edge after o_valid && i_ready is seen.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (hs_pending) begin
      hs_pending = 0;
      inflight   = 0;
      have_cur   = 0;
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1 i_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on each new result, checks hold-stability
  // while back-pressured, and checks o_ready against the outstanding state.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("o_ready", 32'(o_ready), 32'(!inflight));
      if (o_valid) begin
        if (!have_cur) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL spurious_valid got=1 expected=0 at cycle %0d", cyc);
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
            chk("quotient", 32'(o_quotient), 32'(cur.q));
            chk("remainder", 32'(o_remainder), 32'(cur.r));
            chk("dbz", 32'(o_dbz), 32'(cur.dbz));
            chk("latency", 32'(cyc - cur.k), 32'(cur.lat));
          end
        end else begin
          chk("hold_quotient", 32'(o_quotient), 32'(cur.q));
          chk("hold_remainder", 32'(o_remainder), 32'(cur.r));
          chk("hold_dbz", 32'(o_dbz), 32'(cur.dbz));
        end
        if (i_ready) hs_pending = 1;
      end
    end
  end

  task automatic send(input int a, input int b);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      chk("send_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_valid    = 1'b1;
    i_dividend = DW'(a);
    i_divisor  = SW'(b);
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    inflight = 1;
    sb.push_back(model(a, b, cyc));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((inflight || sb.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (inflight || sb.size() != 0) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_quotient", 32'(o_quotient), 32'd0);
    chk("rst_remainder", 32'(o_remainder), 32'd0);
    chk("rst_dbz", 32'(o_dbz), 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;

    send(13, 3);
    wait_idle();
    send(15, 1);
    wait_idle();
    send(2, 3);
    wait_idle();
    send(9, 0);
    wait_idle();

    // Back-pressure: hold the result for several cycles.
    @(posedge clk);
    #1 i_ready = 1'b0;
    send(14, 2);
    t = 0;
    while (!o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 32'(o_valid), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_idle();

    // Reset in the middle of an iteration discards it.
    send(11, 3);
    @(posedge clk);
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    inflight   = 0;
    have_cur   = 0;
    hs_pending = 0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    send(11, 3);
    wait_idle();

    // Operand pulses while busy must be ignored.
    send(7, 2);
    @(negedge clk);
    i_valid    = 1'b1;
    i_dividend = 4'd15;
    i_divisor  = 2'd1;
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Randomized operands with random back-pressure.
    bp_en = 1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, (1 << DW) - 1)), int'($urandom_range(0, (1 << SW) - 1)));
    end
    wait_idle();
    bp_en = 0;
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
